// File: rtl/axi_lite_regfile_if.sv
// Bus bundle for the register-file slave: aw/w/b/ar/r channels, each a rdy/ack pair.
// The source drives rdy, the sink drives ack; a transfer happens on a rising clk edge when both are high.
interface axi_lite_regfile_if;
    logic        aw_rdy;
    logic        aw_ack;
    logic [5:0]  aw;
    logic        w_rdy;
    logic        w_ack;
    logic [31:0] w;
    logic        b_rdy;
    logic        b_ack;
    logic [1:0]  b;
    logic        ar_rdy;
    logic        ar_ack;
    logic [5:0]  ar;
    logic        r_rdy;
    logic        r_ack;
    logic [31:0] r;

    modport master (
        output aw_rdy, aw, w_rdy, w, b_ack, ar_rdy, ar, r_ack,
        input  aw_ack, w_ack, b_rdy, b, ar_ack, r_rdy, r
    );

    modport slave (
        input  aw_rdy, aw, w_rdy, w, b_ack, ar_rdy, ar, r_ack,
        output aw_ack, w_ack, b_rdy, b, ar_ack, r_rdy, r
    );
endinterface

// File: rtl/axi_lite_regfile.sv
// 16 x 32-bit register-file slave with independent write and read FSMs.
// Register 15 is a read-only ID; writing it returns SLVERR.
module axi_lite_regfile #(
    parameter logic [31:0] ID_VALUE = 32'h4E49_434F,
    parameter logic [31:0] RST_VAL  = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    axi_lite_regfile_if.slave  bus,
    output logic [1:0]         dbg_state
);
    typedef enum logic {W_COLLECT = 1'b0, W_RESP = 1'b1} w_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    w_state_t    w_state, w_state_next;
    r_state_t    r_state, r_state_next;
    logic [31:0] regs [15];

    logic        aw_held, w_held;
    logic [3:0]  aw_idx;
    logic [31:0] w_data;
    logic        aw_fire, w_fire, b_fire, ar_fire, r_fire;
    logic        commit;
    logic [3:0]  wr_idx;
    logic [31:0] wr_data;
    logic [3:0]  rd_idx;
    logic        unused_addr_bits;

    assign aw_fire = bus.aw_rdy && bus.aw_ack;
    assign w_fire  = bus.w_rdy && bus.w_ack;
    assign b_fire  = bus.b_rdy && bus.b_ack;
    assign ar_fire = bus.ar_rdy && bus.ar_ack;
    assign r_fire  = bus.r_rdy && bus.r_ack;

    // Address and data may arrive on the same edge, so the live bus value stands in for a missing latch.
    assign commit  = (w_state == W_COLLECT) && (aw_held || aw_fire) && (w_held || w_fire);
    assign wr_idx  = aw_held ? aw_idx : bus.aw[5:2];
    assign wr_data = w_held ? w_data : bus.w;
    assign rd_idx  = bus.ar[5:2];

    assign unused_addr_bits = ^{bus.aw[1:0], bus.ar[1:0]};
    assign dbg_state = {w_state == W_RESP, r_state == R_DATA};

    // Write FSM
    always_ff @(posedge clk) begin
        if (!rst) w_state <= W_COLLECT;
        else      w_state <= w_state_next;
    end

    always_comb begin
        w_state_next = w_state;
        case (w_state)
            W_COLLECT: if (commit) w_state_next = W_RESP;
            W_RESP:    if (b_fire) w_state_next = W_COLLECT;
            default:   w_state_next = W_COLLECT;
        endcase
    end

    always_comb begin
        bus.aw_ack = 1'b0;
        bus.w_ack  = 1'b0;
        bus.b_rdy  = 1'b0;
        case (w_state)
            W_COLLECT: begin
                bus.aw_ack = rst && !aw_held;
                bus.w_ack  = rst && !w_held;
            end
            W_RESP:  bus.b_rdy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            aw_idx  <= 4'd0;
            w_data  <= 32'd0;
            bus.b   <= 2'b00;
            for (int i = 0; i < 15; i++) regs[i] <= RST_VAL;
        end else begin
            if (b_fire) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end else begin
                if (aw_fire) begin
                    aw_held <= 1'b1;
                    aw_idx  <= bus.aw[5:2];
                end
                if (w_fire) begin
                    w_held <= 1'b1;
                    w_data <= bus.w;
                end
            end
            if (commit) begin
                bus.b <= (wr_idx == 4'd15) ? 2'b10 : 2'b00;
                if (wr_idx != 4'd15) regs[wr_idx] <= wr_data;
            end
        end
    end

    // Read FSM
    always_ff @(posedge clk) begin
        if (!rst) r_state <= R_IDLE;
        else      r_state <= r_state_next;
    end

    always_comb begin
        r_state_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_fire) r_state_next = R_DATA;
            R_DATA:  if (r_fire) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    always_comb begin
        bus.ar_ack = 1'b0;
        bus.r_rdy  = 1'b0;
        case (r_state)
            R_IDLE:  bus.ar_ack = rst;
            R_DATA:  bus.r_rdy = 1'b1;
            default: ;
        endcase
    end

    // Sampling regs with a non-blocking update means a same-edge write is seen only by later reads.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.r <= 32'd0;
        end else if (ar_fire) begin
            bus.r <= (rd_idx == 4'd15) ? ID_VALUE : regs[rd_idx];
        end
    end
endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench for axi_lite_regfile: drivers push expected b/r responses into queues,
// a negedge monitor pops and compares whenever a response handshake is about to fire.
module tb_axi_lite_regfile;
    localparam logic [31:0] ID  = 32'h4E49_434F;
    localparam logic [31:0] RST = 32'h0000_0000;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [1:0]  exp_b_q[$];
    logic [31:0] exp_r_q[$];

    axi_lite_regfile_if bus_if();

    axi_lite_regfile #(.ID_VALUE(ID), .RST_VAL(RST)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if.slave),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: a response is consumed on the edge following a negedge with rdy&&ack.
    always @(negedge clk) begin
        if (rst && bus_if.b_rdy && bus_if.b_ack) begin
            if (exp_b_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL b_unexpected: got b=%h, no response expected", bus_if.b);
            end else begin
                check("b_resp", 32'(bus_if.b), 32'(exp_b_q.pop_front()));
            end
        end
        if (rst && bus_if.r_rdy && bus_if.r_ack) begin
            if (exp_r_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL r_unexpected: got r=%h, no response expected", bus_if.r);
            end else begin
                check("r_data", bus_if.r, exp_r_q.pop_front());
            end
        end
    end

    // ch: 0=aw, 1=w, 2=ar. Returns #1 after the accepting edge.
    task automatic send(input int ch, input logic [31:0] val);
        bit done = 1'b0;
        case (ch)
            0: begin bus_if.aw = val[5:0]; bus_if.aw_rdy = 1'b1; end
            1: begin bus_if.w = val;       bus_if.w_rdy  = 1'b1; end
            default: begin bus_if.ar = val[5:0]; bus_if.ar_rdy = 1'b1; end
        endcase
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            case (ch)
                0: done = bus_if.aw_ack;
                1: done = bus_if.w_ack;
                default: done = bus_if.ar_ack;
            endcase
            @(posedge clk);
            #1;
        end
        case (ch)
            0: bus_if.aw_rdy = 1'b0;
            1: bus_if.w_rdy  = 1'b0;
            default: bus_if.ar_rdy = 1'b0;
        endcase
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL ack_timeout: channel %0d never acked, required ack within 20 cycles", ch);
        end
    endtask

    task automatic write_txn(input logic [5:0] a, input logic [31:0] d, input logic [1:0] exp);
        exp_b_q.push_back(exp);
        fork
            send(0, 32'(a));
            send(1, d);
        join
        tick(3);
    endtask

    task automatic read_txn(input logic [5:0] a, input logic [31:0] exp);
        exp_r_q.push_back(exp);
        send(2, 32'(a));
        tick(2);
    endtask

    initial begin
        rst = 1'b0;
        bus_if.aw_rdy = 1'b0; bus_if.aw = 6'h0;
        bus_if.w_rdy  = 1'b0; bus_if.w  = 32'h0;
        bus_if.ar_rdy = 1'b0; bus_if.ar = 6'h0;
        bus_if.b_ack  = 1'b1; bus_if.r_ack = 1'b1;
        tick(2);

        // Reset state
        check("rst_b_rdy", 32'(bus_if.b_rdy), 32'd0);
        check("rst_r_rdy", 32'(bus_if.r_rdy), 32'd0);
        check("rst_b", 32'(bus_if.b), 32'd0);
        check("rst_r", bus_if.r, 32'd0);
        check("rst_aw_ack", 32'(bus_if.aw_ack), 32'd0);
        check("rst_ar_ack", 32'(bus_if.ar_ack), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_aw_ack", 32'(bus_if.aw_ack), 32'd1);
        check("idle_w_ack", 32'(bus_if.w_ack), 32'd1);
        check("idle_ar_ack", 32'(bus_if.ar_ack), 32'd1);

        // Address first, data two cycles later
        exp_b_q.push_back(2'b00);
        bus_if.aw = 6'h0C; bus_if.aw_rdy = 1'b1;
        tick(1);
        bus_if.aw_rdy = 1'b0;
        tick(1);
        bus_if.w = 32'hDEAD_BEEF; bus_if.w_rdy = 1'b1;
        @(negedge clk);
        check("wlat_before", 32'(bus_if.b_rdy), 32'd0);
        tick(1);
        bus_if.w_rdy = 1'b0;
        check("wlat_after", 32'(bus_if.b_rdy), 32'd1);
        tick(2);
        exp_r_q.push_back(32'hDEAD_BEEF);
        bus_if.ar = 6'h0C; bus_if.ar_rdy = 1'b1;
        tick(1);
        bus_if.ar_rdy = 1'b0;
        check("rlat_after", 32'(bus_if.r_rdy), 32'd1);
        tick(2);

        // Data three cycles before address, then both in the same cycle
        exp_b_q.push_back(2'b00);
        bus_if.w = 32'h0000_1234; bus_if.w_rdy = 1'b1;
        tick(1);
        bus_if.w_rdy = 1'b0;
        tick(2);
        send(0, 32'h04);
        tick(3);
        write_txn(6'h08, 32'h5, 2'b00);
        read_txn(6'h04, 32'h0000_1234);
        read_txn(6'h08, 32'h5);

        // Read-only ID register
        write_txn(6'h3C, 32'hFFFF_FFFF, 2'b10);
        read_txn(6'h3C, ID);

        // Write response backpressure; new aw/w offered must not be taken
        bus_if.b_ack = 1'b0;
        exp_b_q.push_back(2'b00);
        fork
            send(0, 32'h10);
            send(1, 32'hA5A5_0001);
        join
        bus_if.aw = 6'h14; bus_if.aw_rdy = 1'b1;
        bus_if.w = 32'hBAD0_BAD0; bus_if.w_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_b_rdy", 32'(bus_if.b_rdy), 32'd1);
            check("bp_b", 32'(bus_if.b), 32'd0);
            check("bp_aw_ack", 32'(bus_if.aw_ack), 32'd0);
            check("bp_w_ack", 32'(bus_if.w_ack), 32'd0);
            tick(1);
        end
        check("bp_dbg_state", 32'(dbg_state), 32'd2);
        bus_if.aw_rdy = 1'b0; bus_if.w_rdy = 1'b0;
        bus_if.b_ack = 1'b1;
        tick(2);
        read_txn(6'h14, RST);

        // Read data backpressure
        bus_if.r_ack = 1'b0;
        exp_r_q.push_back(32'hA5A5_0001);
        send(2, 32'h10);
        bus_if.ar = 6'h04; bus_if.ar_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_r_rdy", 32'(bus_if.r_rdy), 32'd1);
            check("bp_r", bus_if.r, 32'hA5A5_0001);
            check("bp_ar_ack", 32'(bus_if.ar_ack), 32'd0);
            tick(1);
        end
        bus_if.ar_rdy = 1'b0;
        bus_if.r_ack = 1'b1;
        tick(2);

        // Same-edge read and write to index 2: read sees the old value
        exp_b_q.push_back(2'b00);
        exp_r_q.push_back(32'h5);
        bus_if.aw = 6'h08; bus_if.aw_rdy = 1'b1;
        bus_if.w  = 32'h9; bus_if.w_rdy  = 1'b1;
        bus_if.ar = 6'h08; bus_if.ar_rdy = 1'b1;
        tick(1);
        bus_if.aw_rdy = 1'b0; bus_if.w_rdy = 1'b0; bus_if.ar_rdy = 1'b0;
        tick(3);
        read_txn(6'h08, 32'h9);

        // Reset with both responses pending; the pending responses are dropped
        bus_if.b_ack = 1'b0;
        bus_if.r_ack = 1'b0;
        fork
            send(0, 32'h3C);
            send(1, 32'h77);
            send(2, 32'h04);
        join
        check("pre_rst_b_rdy", 32'(bus_if.b_rdy), 32'd1);
        check("pre_rst_r_rdy", 32'(bus_if.r_rdy), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("in_rst_aw_ack", 32'(bus_if.aw_ack), 32'd0);
        check("in_rst_w_ack", 32'(bus_if.w_ack), 32'd0);
        check("in_rst_ar_ack", 32'(bus_if.ar_ack), 32'd0);
        tick(1);
        check("mid_rst_b_rdy", 32'(bus_if.b_rdy), 32'd0);
        check("mid_rst_r_rdy", 32'(bus_if.r_rdy), 32'd0);
        check("mid_rst_b", 32'(bus_if.b), 32'd0);
        check("mid_rst_r", bus_if.r, 32'd0);
        rst = 1'b1;
        bus_if.b_ack = 1'b1;
        bus_if.r_ack = 1'b1;
        @(negedge clk);
        check("post_rst_aw_ack", 32'(bus_if.aw_ack), 32'd1);
        check("post_rst_w_ack", 32'(bus_if.w_ack), 32'd1);
        check("post_rst_ar_ack", 32'(bus_if.ar_ack), 32'd1);
        tick(1);
        read_txn(6'h04, RST);
        read_txn(6'h08, RST);
        read_txn(6'h0C, RST);
        read_txn(6'h10, RST);
        read_txn(6'h3C, ID);

        tick(2);
        check("queues_empty", 32'(exp_b_q.size() + exp_r_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
